// File: rtl/irq_priority_encoder8.sv
// Registered 8-source interrupt priority encoder: rising-edge request latching,
// per-source mask, and a valid/ack grant handshake (bit 7 has highest priority).
module irq_priority_encoder8 #(
    parameter logic [7:0] RESET_MASK = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       ack,
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] mask,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] clr;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [2:0] highestIdx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_q     <= 8'h00;
            pending_q <= 8'h00;
            mask_q    <= RESET_MASK;
            valid_q   <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        code_d   = code_q;
        clr      = 8'h00;
        rise     = req & ~req_q;
        eligible = pending_q & mask_q;

        case (state_q)
            IDLE: begin
                if (en && (eligible != 8'h00)) begin
                    code_d  = highestIdx(eligible);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Ack takes precedence over a withdraw caused by a late mask write.
                if (ack) begin
                    clr     = 8'h01 << code_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (!mask_q[code_q]) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A fresh edge on the bit being acked survives as a new event.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    assign valid   = valid_q;
    assign code    = code_q;
    assign mask    = mask_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder8.sv
// Bench for irq_priority_encoder8: directed scenarios followed by random traffic,
// checked against a per-source behavioural model and a grant scoreboard.
module tb_irq_priority_encoder8;

    localparam logic [7:0] RESET_MASK = 8'hFF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic [7:0] mask;
    logic [7:0] pending;

    int total = 0;
    int bad   = 0;
    int expQ[$];

    bit mValid;
    int mCode;
    bit mPend[8];
    bit mMask[8];
    bit mPrev[8];
    bit prevValid;

    always #5 clk = ~clk;

    irq_priority_encoder8 #(.RESET_MASK(RESET_MASK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .valid      (valid),
        .code       (code),
        .mask       (mask),
        .pending    (pending)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] packBits(input bit b[8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = b[i];
        return v;
    endfunction

    // Reference model: each source is an independent pending flag; a grant goes
    // to the highest enabled pending source whenever nothing is being presented.
    always @(posedge clk or negedge reset_n) begin : model
        bit nPend[8];
        bit accepted;
        bit withdraw;
        int top;
        if (!reset_n) begin
            mValid = 0;
            mCode  = 0;
            for (int i = 0; i < 8; i++) begin
                mPend[i] = 0;
                mPrev[i] = 0;
                mMask[i] = RESET_MASK[i];
            end
            expQ.delete();
        end else begin
            accepted = mValid && ack;
            withdraw = mValid && !ack && !mMask[mCode];
            for (int i = 0; i < 8; i++) begin
                nPend[i] = mPend[i];
                if (accepted && i == mCode) nPend[i] = 0;
                if (req[i] && !mPrev[i]) nPend[i] = 1;
            end
            top = -1;
            if (!mValid && en) begin
                for (int i = 0; i < 8; i++) begin
                    if (mPend[i] && mMask[i]) top = i;
                end
            end
            if (top >= 0) begin
                mValid = 1;
                mCode  = top;
                expQ.push_back(top);
            end else if (accepted || withdraw) begin
                mValid = 0;
            end
            for (int i = 0; i < 8; i++) begin
                mPend[i] = nPend[i];
                if (mask_we) mMask[i] = mask_wdata[i];
                mPrev[i] = req[i];
            end
        end
    end

    // Monitor: compares visible state every cycle and pops the scoreboard on each new grant.
    always @(negedge clk) begin : monitor
        int e;
        if (reset_n) begin
            checkOutput("valid", int'(valid), int'(mValid));
            checkOutput("pending", int'(pending), int'(packBits(mPend)));
            checkOutput("mask", int'(mask), int'(packBits(mMask)));
            if (mValid) checkOutput("code", int'(code), mCode);
            if (valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("grant_unexpected", int'(code), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grant_code", int'(code), e);
                end
            end
        end
        prevValid = valid;
    end

    task automatic applyStimulus(input logic [7:0] r, input logic e, input logic a,
                                 input logic we, input logic [7:0] wd);
        req        = r;
        en         = e;
        ack        = a;
        mask_we    = we;
        mask_wdata = wd;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] lastR;
        reset_n    = 1'b0;
        en         = 1'b1;
        req        = 8'h00;
        ack        = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        prevValid  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_code", int'(code), 0);
        checkOutput("rst_pending", int'(pending), 8'h00);
        checkOutput("rst_mask", int'(mask), 8'hFF);

        // Single request on source 5.
        applyStimulus(8'h20, 1, 0, 0, 8'h00);
        checkOutput("single_pending", int'(pending), 8'h20);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("single_valid", int'(valid), 1);
        checkOutput("single_code", int'(code), 5);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        checkOutput("single_ack_valid", int'(valid), 0);
        checkOutput("single_ack_pending", int'(pending), 8'h00);

        // Three simultaneous requests served in priority order.
        applyStimulus(8'h8A, 1, 0, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("multi_code7", int'(code), 7);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        checkOutput("multi_bubble", int'(valid), 0);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("multi_code3", int'(code), 3);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("multi_code1", int'(code), 1);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);

        // Mask out source 7, then re-enable it, then withdraw it.
        applyStimulus(8'h00, 1, 0, 1, 8'h7F);
        applyStimulus(8'h84, 1, 0, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("mask_code2", int'(code), 2);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("mask_pending80", int'(pending), 8'h80);
        checkOutput("mask_novalid", int'(valid), 0);
        applyStimulus(8'h00, 1, 0, 1, 8'hFF);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("unmask_code7", int'(code), 7);
        applyStimulus(8'h00, 1, 0, 1, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("withdraw_valid", int'(valid), 0);
        checkOutput("withdraw_pending", int'(pending), 8'h80);
        applyStimulus(8'h00, 1, 0, 1, 8'hFF);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);

        // Re-request on the same cycle as its ack.
        applyStimulus(8'h10, 1, 0, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        applyStimulus(8'h10, 1, 1, 0, 8'h00);
        checkOutput("rereq_pending", int'(pending), 8'h10);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("rereq_code4", int'(code), 4);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);

        // Higher-priority arrival does not preempt; ack while idle is ignored.
        applyStimulus(8'h08, 1, 0, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        applyStimulus(8'h40, 1, 0, 0, 8'h00);
        checkOutput("nopreempt_code3", int'(code), 3);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("after_code6", int'(code), 6);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        applyStimulus(8'h00, 1, 1, 0, 8'h00);
        checkOutput("idle_ack_valid", int'(valid), 0);

        // Enable gating.
        applyStimulus(8'h01, 0, 0, 0, 8'h00);
        repeat (3) applyStimulus(8'h00, 0, 0, 0, 8'h00);
        checkOutput("en_low_valid", int'(valid), 0);
        applyStimulus(8'h00, 1, 0, 0, 8'h00);
        checkOutput("en_high_code0", int'(code), 0);
        checkOutput("en_high_valid", int'(valid), 1);

        // Asynchronous reset in the middle of a grant.
        applyStimulus(8'h02, 1, 0, 0, 8'h00);
        req = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", int'(valid), 0);
        checkOutput("async_rst_pending", int'(pending), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic.
        lastR = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) lastR = 8'($urandom);
            applyStimulus(lastR, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 15) == 0), 8'($urandom) | 8'($urandom));
        end

        applyStimulus(8'h00, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
